// File: rtl/simple_dual_port_ram_ext_if.sv
// Bus bundle for simple_dual_port_ram_ext: write port, read port and status.
// The master side drives requests and the slave side is the RAM itself.
interface simple_dual_port_ram_ext_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic                  we;
    logic [NB-1:0]         be;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  re;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;
    logic                  busy;

    modport master (
        output data, write_addr, we, be, read_addr, re,
        input  q, q_valid, busy
    );

    modport slave (
        input  data, write_addr, we, be, read_addr, re,
        output q, q_valid, busy
    );
endinterface

// File: rtl/simple_dual_port_ram_ext.sv
// Single-clock simple dual-port RAM with byte-lane writes, selectable
// read-during-write behaviour, optional output register, read-valid
// tracking and a post-reset clearing sweep.
module simple_dual_port_ram_ext #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 6,
    parameter int BYTE_WIDTH    = 8,
    parameter int RDW_NEW       = 0,
    parameter int OUT_REG       = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    simple_dual_port_ram_ext_if.slave bus
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic [DATA_WIDTH-1:0] rd_old_s;
    logic [DATA_WIDTH-1:0] merged_s;
    logic [DATA_WIDTH-1:0] s1_data_d;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic                  s1_valid_q;

    // Accesses are only honoured once the clearing sweep has finished.
    assign wr_acc_s = bus.we && (state_q == ST_READY);
    assign rd_acc_s = bus.re && (state_q == ST_READY);
    assign bus.busy = (state_q == ST_CLEAR);

    // Sweep controller: walk every address once after reset, then serve traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= (INIT_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_q <= ST_READY;
                    end
                end
                ST_READY: begin
                    state_q <= ST_READY;
                end
                default: begin
                    state_q <= ST_READY;
                end
            endcase
        end
    end

    // Storage array: sweep zeroing or byte-lane writes; no reset on purpose.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_acc_s) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.be[i]) begin
                    mem_q[bus.write_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                        bus.data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read word selection, with optional bypass of a same-address write.
    always_comb begin
        rd_old_s = mem_q[bus.read_addr];
        merged_s = rd_old_s;
        for (int i = 0; i < NB; i++) begin
            if (wr_acc_s && bus.be[i]) begin
                merged_s[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                merged_s[i*BYTE_WIDTH +: BYTE_WIDTH] = rd_old_s[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        if ((RDW_NEW != 0) && wr_acc_s && (bus.write_addr == bus.read_addr)) begin
            s1_data_d = merged_s;
        end else begin
            s1_data_d = rd_old_s;
        end
    end

    // Stage 1: capture accepted reads; hold data when no read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_acc_s;
            if (rd_acc_s) begin
                s1_data_q <= s1_data_d;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] s2_data_q;
            logic                  s2_valid_q;

            // Stage 2: extra output register, valid travels in lockstep.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_data_q  <= '0;
                    s2_valid_q <= 1'b0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        s2_data_q <= s1_data_q;
                    end
                end
            end

            assign bus.q       = s2_data_q;
            assign bus.q_valid = s2_valid_q;
        end else begin : g_noreg
            assign bus.q       = s1_data_q;
            assign bus.q_valid = s1_valid_q;
        end
    endgenerate
endmodule

// File: tb/tb_simple_dual_port_ram_ext.sv
// Directed bench: dut0 uses defaults (8-bit, old-data RDW, no output reg);
// dut1 is 32-bit with new-data RDW and the output register.
module tb_simple_dual_port_ram_ext;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   n;
    bit   qv;

    simple_dual_port_ram_ext_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(6), .BYTE_WIDTH(8)) b0 ();
    simple_dual_port_ram_ext_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_WIDTH(8)) b1 ();

    simple_dual_port_ram_ext #(
        .DATA_WIDTH(8), .ADDR_WIDTH(6), .BYTE_WIDTH(8),
        .RDW_NEW(0), .OUT_REG(0), .INIT_ON_RESET(1)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(b0.slave)
    );

    simple_dual_port_ram_ext #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_WIDTH(8),
        .RDW_NEW(1), .OUT_REG(1), .INIT_ON_RESET(1)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        b0.we = 1'b0; b0.re = 1'b0; b0.data = 8'h00; b0.be = 1'b0;
        b0.write_addr = 6'd0; b0.read_addr = 6'd0;
        b1.we = 1'b0; b1.re = 1'b0; b1.data = 32'h0; b1.be = 4'h0;
        b1.write_addr = 6'd0; b1.read_addr = 6'd0;
    endtask

    // Hammer both ports while busy; count busy cycles and note any q_valid.
    task automatic sweep(output int cnt, output bit seen);
        cnt  = 0;
        seen = 1'b0;
        while (b0.busy && cnt < 200) begin
            b0.we = 1'b1; b0.re = 1'b1; b0.data = 8'hFF; b0.be = 1'b1;
            b0.write_addr = cnt[5:0]; b0.read_addr = cnt[5:0];
            b1.we = 1'b1; b1.re = 1'b1; b1.data = 32'hFFFF_FFFF; b1.be = 4'hF;
            b1.write_addr = cnt[5:0]; b1.read_addr = cnt[5:0];
            step();
            cnt++;
            if (b0.q_valid || b1.q_valid) seen = 1'b1;
        end
        idle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clk = 1'b0;
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_busy0", {31'd0, b0.busy}, 32'd1);
        chk("rst_busy1", {31'd0, b1.busy}, 32'd1);
        chk("rst_q0", {24'd0, b0.q}, 32'd0);
        chk("rst_qv0", {31'd0, b0.q_valid}, 32'd0);
        chk("rst_q1", b1.q, 32'd0);
        chk("rst_qv1", {31'd0, b1.q_valid}, 32'd0);

        // Sweep length with accesses attempted throughout
        rst = 1'b0;
        sweep(n, qv);
        chk("sweep_len", n, 32'd64);
        chk("sweep_no_qv", {31'd0, qv}, 32'd0);
        chk("sweep_busy1", {31'd0, b1.busy}, 32'd0);
        chk("sweep_q0", {24'd0, b0.q}, 32'd0);

        // All locations zero, one result per cycle at latency 1
        for (int i = 0; i < 64; i++) begin
            b0.re = 1'b1;
            b0.read_addr = i[5:0];
            step();
            chk("zero_q", {24'd0, b0.q}, 32'd0);
            chk("zero_qv", {31'd0, b0.q_valid}, 32'd1);
        end
        b0.re = 1'b0;
        step();
        chk("zero_qv_end", {31'd0, b0.q_valid}, 32'd0);

        // Byte lanes on the 32-bit instance
        b1.we = 1'b1; b1.write_addr = 6'd5; b1.data = 32'hAABB_CCDD; b1.be = 4'b1111;
        step();
        b1.data = 32'h1122_3344; b1.be = 4'b0101;
        step();
        b1.data = 32'hFFFF_FFFF; b1.be = 4'b0000;
        step();
        b1.we = 1'b0; b1.re = 1'b1; b1.read_addr = 6'd5;
        step();
        chk("lane_lat1_qv", {31'd0, b1.q_valid}, 32'd0);
        b1.re = 1'b0;
        step();
        chk("lane_q", b1.q, 32'hAA22_CC44);
        chk("lane_qv", {31'd0, b1.q_valid}, 32'd1);

        // Write at edge N visible to read sampled at N+1
        b0.we = 1'b1; b0.write_addr = 6'd9; b0.data = 8'h5A; b0.be = 1'b1;
        step();
        b0.we = 1'b0; b0.re = 1'b1; b0.read_addr = 6'd9;
        step();
        chk("wr_then_rd", {24'd0, b0.q}, 32'h5A);
        b0.re = 1'b0;

        // Read-during-write on both instances
        b0.we = 1'b1; b0.write_addr = 6'd3; b0.data = 8'h10; b0.be = 1'b1;
        b1.we = 1'b1; b1.write_addr = 6'd3; b1.data = 32'h10; b1.be = 4'hF;
        step();
        b0.data = 8'h20; b0.re = 1'b1; b0.read_addr = 6'd3;
        b1.data = 32'h20; b1.re = 1'b1; b1.read_addr = 6'd3;
        step();
        chk("rdw_old_q", {24'd0, b0.q}, 32'h10);
        chk("rdw_old_qv", {31'd0, b0.q_valid}, 32'd1);
        b0.we = 1'b0; b1.we = 1'b0;
        step();
        chk("rdw_next0", {24'd0, b0.q}, 32'h20);
        chk("rdw_new_q", b1.q, 32'h20);
        chk("rdw_new_qv", {31'd0, b1.q_valid}, 32'd1);
        b0.re = 1'b0; b1.re = 1'b0;
        step();
        chk("rdw_next1", b1.q, 32'h20);
        chk("hold_qv0", {31'd0, b0.q_valid}, 32'd0);
        chk("hold_q0", {24'd0, b0.q}, 32'h20);

        // Partial-lane bypass on the new-data instance
        b1.we = 1'b1; b1.write_addr = 6'd7; b1.data = 32'hDEAD_BEEF; b1.be = 4'hF;
        step();
        b1.data = 32'h0000_0011; b1.be = 4'b0001; b1.re = 1'b1; b1.read_addr = 6'd7;
        step();
        b1.we = 1'b0; b1.re = 1'b0;
        step();
        chk("rdw_merge", b1.q, 32'hDEAD_BE11);

        // Output register pipeline: three back-to-back reads
        b1.we = 1'b1; b1.be = 4'hF;
        b1.write_addr = 6'd0; b1.data = 32'hA0; step();
        b1.write_addr = 6'd1; b1.data = 32'hA1; step();
        b1.write_addr = 6'd2; b1.data = 32'hA2; step();
        b1.we = 1'b0; b1.re = 1'b1; b1.read_addr = 6'd0;
        step();
        chk("oreg_qv_lat", {31'd0, b1.q_valid}, 32'd0);
        b1.read_addr = 6'd1;
        step();
        chk("oreg_q0", b1.q, 32'hA0);
        chk("oreg_qv0", {31'd0, b1.q_valid}, 32'd1);
        b1.read_addr = 6'd2;
        step();
        chk("oreg_q1", b1.q, 32'hA1);
        chk("oreg_qv1", {31'd0, b1.q_valid}, 32'd1);
        b1.re = 1'b0;
        step();
        chk("oreg_q2", b1.q, 32'hA2);
        chk("oreg_qv2", {31'd0, b1.q_valid}, 32'd1);
        step();
        chk("oreg_qv_end", {31'd0, b1.q_valid}, 32'd0);
        chk("oreg_hold", b1.q, 32'hA2);

        // Reset with reads in flight, then reset mid-sweep
        b0.we = 1'b1; b0.write_addr = 6'd40; b0.data = 8'h55; b0.be = 1'b1;
        b1.we = 1'b1; b1.write_addr = 6'd40; b1.data = 32'h55; b1.be = 4'hF;
        step();
        b0.we = 1'b0; b1.we = 1'b0;
        b0.re = 1'b1; b0.read_addr = 6'd40;
        b1.re = 1'b1; b1.read_addr = 6'd40;
        step();
        chk("pre_rst_q0", {24'd0, b0.q}, 32'h55);
        b0.re = 1'b0; b1.re = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("async_q0", {24'd0, b0.q}, 32'd0);
        chk("async_qv0", {31'd0, b0.q_valid}, 32'd0);
        chk("async_q1", b1.q, 32'd0);
        chk("async_qv1", {31'd0, b1.q_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) step();
        chk("mid_busy", {31'd0, b0.busy}, 32'd1);
        chk("mid_qv1", {31'd0, b1.q_valid}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sweep(n, qv);
        chk("resweep_len", n, 32'd64);
        chk("resweep_no_qv", {31'd0, qv}, 32'd0);
        b0.re = 1'b1; b0.read_addr = 6'd40;
        b1.re = 1'b1; b1.read_addr = 6'd40;
        step();
        chk("clr40_q0", {24'd0, b0.q}, 32'd0);
        chk("clr40_qv0", {31'd0, b0.q_valid}, 32'd1);
        b0.re = 1'b0; b1.re = 1'b0;
        step();
        chk("clr40_q1", b1.q, 32'd0);
        chk("clr40_qv1", {31'd0, b1.q_valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/simple_dual_port_ram_ext.md
# simple_dual_port_ram_ext

Parametrised successor to the team's single-clock simple dual-port RAM, adding byte-lane write enables, a selectable read-during-write mode, an optional output pipeline register, read-valid tracking and a post-reset clearing sweep. It sits wherever a buffer or lookup store needs deterministic contents after reset and known read latency, for example behind FIFO controllers and packet buffers. One write port and one read port share a single clock domain.

## Interface
- DATA_WIDTH, 8: word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 6: address width; depth = 2**ADDR_WIDTH.
- BYTE_WIDTH, 8: lane width; NB = DATA_WIDTH/BYTE_WIDTH lanes.
- RDW_NEW, 0: read-during-write to the same address. 0 returns the old word; 1 returns the new, merged word via bypass.
- OUT_REG, 0: 1 adds an output register stage.
- INIT_ON_RESET, 1: 1 clears every location to 0 after reset.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; asynchronous, active-high.
- data  in  DATA_WIDTH  write data.
- write_addr  in  ADDR_WIDTH  write address.
- we  in  1  write enable.
- be  in  NB  byte-lane enable; lane i covers data[i*BYTE_WIDTH +: BYTE_WIDTH].
- read_addr  in  ADDR_WIDTH  read address.
- re  in  1  read enable.
- q  out  DATA_WIDTH  read data.
- q_valid  out  1  high for one cycle when q carries the result of an accepted read.
- busy  out  1  high while the clearing sweep runs; we and re are ignored while busy.

## Operation
- State machine: CLEAR, READY.
  - While rst is high, the state is forced to CLEAR if INIT_ON_RESET=1, otherwise to READY.
  - The sweep counter is forced to 0.
- CLEAR behaviour:
  - Each cycle writes 0 to ram[cnt] and increments cnt.
  - When cnt == 2**ADDR_WIDTH-1, that write is performed and the state moves to READY.
  - busy = (state == CLEAR).
- Reset during CLEAR aborts the sweep; it restarts from address 0 after release.
- The storage array has no reset. Only the sweep initialises it.
- Write (READY, we=1): for each lane with be[i]=1, ram[write_addr] lane i <= data lane i. Lanes with be[i]=0 keep their value. we=1 with be=0 is a no-op.
- Read (READY, re=1): ram[read_addr] is sampled into stage 1.
  - OUT_REG=0: stage 1 drives q.
  - OUT_REG=1: stage 1 feeds an output register that drives q.
- re=0: q holds its previous value, and q_valid is 0 for that slot.
- Same-address read and write in one cycle:
  - RDW_NEW=0: q is the pre-write word.
  - RDW_NEW=1: q is the merged word, with enabled lanes from data and the remaining lanes from the old word.
- Different addresses: the two ports are fully independent.
- Reads issued during busy are dropped and never produce q_valid.

## Timing
- Reset values:
  - q = 0 and q_valid = 0.
  - Internal stage registers = 0.
  - busy = 1 if INIT_ON_RESET=1, else 0.
- Clearing takes exactly 2**ADDR_WIDTH cycles after rst deasserts. busy falls on the edge that completes the last clear write, so the first accepted access is in the following cycle.
- Read latency is the number of edges from re sampled high to q/q_valid updated: 1 with OUT_REG=0, 2 with OUT_REG=1. q_valid is pipelined in lockstep with q.
- A write at edge N is visible to a read sampled at edge N+1 regardless of RDW_NEW.
- Back-to-back reads every cycle give one result per cycle with no bubbles.
- Reset asserted with reads in flight: all pending results are discarded, and q and q_valid return to 0 asynchronously.

## Test plan
- Reset with defaults: busy is high for exactly 64 cycles after release. Reading all 64 addresses afterwards returns 0x00 each, with q_valid pulsing once per read at latency 1.
- Byte lanes (DATA_WIDTH=32): write 0xAABBCCDD to address 5 with be=4'b1111, then write 0x11223344 with be=4'b0101. A read of address 5 returns 0xAA22CC44.
- Read-during-write: ram[3]=0x10, then write 0x20 to address 3 while reading address 3.
  - RDW_NEW=0: q=0x10.
  - RDW_NEW=1: q=0x20.
  - The next read of address 3 returns 0x20 in both cases.
- OUT_REG=1: read addresses 0,1,2 on consecutive cycles after preloading 0xA0,0xA1,0xA2. q shows them 2 cycles after each request, and q_valid stays high for 3 consecutive cycles.
- Reset mid-sweep: assert rst at sweep cycle 30 after first writing 0x55 to address 40 before a previous reset. busy then stays high for 64 cycles after release, and address 40 reads 0x00.
- Access during busy: we=1 and re=1 issued throughout the sweep leave the memory all-zero, and q_valid stays 0 until the first read after busy falls.
